ct_loader: RTL and testbench
============================

# ct_loader

Front-end stage for the ARC4 key cracker. Accepts a length-prefixed ciphertext as a byte stream and writes it into ciphertext memory: length at address 0, bytes at 1..L. It then starts `crack` with a one-cycle enable, waits for it to finish, and holds the recovered key and found flag until the host acknowledges.

## Interface
Parameters:
- none (all widths fixed: 8-bit memory, 24-bit key)

Ports:
- clk  input  1  system clock; all state changes on rising edge
- rst  input  1  one clock; reset is asynchronous and active-high
- in_valid  input  1  stream byte present on in_data
- in_data  input  8  stream byte; first byte of a message is length L, then L ciphertext bytes
- in_ready  output  1  loader accepts in_data this cycle
- ct_sel  output  1  1 = loader owns ct memory port, 0 = crack owns it (drives external mux)
- ct_addr  output  8  ct memory write address
- ct_wrdata  output  8  ct memory write data
- ct_wren  output  1  ct memory write enable
- crack_en  output  1  one-cycle start pulse to crack
- crack_rdy  input  1  crack idle/done
- crack_key  input  24  key from crack, valid when crack_rdy rises
- crack_key_valid  input  1  crack found a printable-plaintext key
- busy  output  1  message in progress (any state other than LEN)
- res_valid  output  1  result registers hold a fresh result
- res_key  output  24  captured key
- res_found  output  1  captured crack_key_valid
- res_ack  input  1  host consumed result

## Operation
- States: LEN, DATA, START, WAIT_BUSY, WAIT_DONE, REPORT.
- Registers:
  - state
  - len[7:0]
  - cnt[7:0], next write address
  - res_key, res_found, res_valid
- LEN:
  - in_ready=1, ct_sel=1.
  - On accept (in_valid&in_ready): write in_data to address 0, len<=in_data, cnt<=1.
  - If in_data==0, go to START; otherwise go to DATA.
- DATA:
  - in_ready=1, ct_sel=1.
  - On accept: write in_data to address cnt.
  - If cnt==len, go to START; otherwise cnt<=cnt+1.
  - The compare happens before the increment, so L=255 ends at address 255 with no wrap.
- Writes are combinational from the accept: ct_wren=in_valid&in_ready, ct_addr=(state==LEN ? 0 : cnt), ct_wrdata=in_data. ct_wren=0 in every other case.
- START:
  - ct_sel=0, in_ready=0.
  - crack_en=crack_rdy (combinational). If crack_rdy=1, go to WAIT_BUSY; otherwise stay.
- WAIT_BUSY:
  - Wait for crack_rdy==0, then go to WAIT_DONE.
  - crack_en=0.
- WAIT_DONE:
  - On crack_rdy==1, capture: res_key<=crack_key, res_found<=crack_key_valid, res_valid<=1. Go to REPORT.
- REPORT:
  - Outputs held stable. On res_ack=1, res_valid<=0 and go to LEN.
  - res_key and res_found keep their values until the next capture.
- res_ack outside REPORT is ignored.
- in_data is ignored whenever in_ready=0. No message is accepted until the previous result is acknowledged.

## Timing
- Reset values (while rst=1 and after):
  - state=LEN, len=0, cnt=0
  - in_ready=0 while rst=1, then 1 in LEN
  - ct_sel=1, ct_wren=0, ct_addr=0, ct_wrdata=0
  - crack_en=0, busy=0
  - res_valid=0, res_key=0, res_found=0
- Throughput: one byte per cycle when in_valid is held. L+1 cycles from first accept to START.
- crack_en:
  - Asserted for exactly one cycle, in the first START cycle with crack_rdy=1.
  - At the earliest, that is the cycle after the last write.
  - ct_sel is already 0 in that cycle.
- res_valid rises the cycle after crack_rdy returns high in WAIT_DONE.
- Fastest turnaround: LEN is re-entered one cycle after res_ack is sampled.
- Reset mid-operation: immediate return to reset values. The partial message is discarded and any pending result is lost. Crack is not signalled; it finishes or is reset separately.

## Test plan
- Reset: assert rst mid-DATA (after 3 of 5 bytes). Required: state LEN, in_ready=0 during rst, all outputs at reset values, next byte treated as a length.
- Normal load: stream 03,A1,B2,C3 back-to-back. Required: writes at addr 0..3 with data 03,A1,B2,C3 on 4 consecutive cycles. Then one crack_en pulse with crack_rdy=1, and ct_sel=0 from START onward.
- Result capture: in WAIT_DONE, model raises crack_rdy with key=0x00AB12, key_valid=1. Required: next cycle res_valid=1, res_key=0x00AB12, res_found=1. Values held until res_ack, res_valid=0 one cycle later.
- Not-found and backpressure: crack_rdy low on START entry for 5 cycles. Required: crack_en=0 throughout, a single pulse when rdy rises. A result with key_valid=0 gives res_found=0.
- Stream gaps: toggle in_valid 1/0 during DATA for L=4. Required: only valid cycles write, and addresses stay contiguous 1..4.
- Boundaries:
  - L=0: START the cycle after the length write, with no DATA writes.
  - L=255: last write at addr 255, then START.
  - res_ack pulsed in DATA: ignored.

Source files
------------

// File: rtl/ct_loader.sv
// Ciphertext loader for the ARC4 cracker: writes a length-prefixed byte stream
// into ct memory, starts crack, and holds its result until the host acknowledges.
module ct_loader (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        ct_sel,
    output logic [7:0]  ct_addr,
    output logic [7:0]  ct_wrdata,
    output logic        ct_wren,
    output logic        crack_en,
    input  logic        crack_rdy,
    input  logic [23:0] crack_key,
    input  logic        crack_key_valid,
    output logic        busy,
    output logic        res_valid,
    output logic [23:0] res_key,
    output logic        res_found,
    input  logic        res_ack
);

    typedef enum logic [2:0] {
        LEN, DATA, START, WAIT_BUSY, WAIT_DONE, REPORT
    } state_t;

    state_t     state;
    logic [7:0] len;
    logic [7:0] cnt;
    logic       load_phase;
    logic       accept;

    // Handshake: a byte transfers on every rising edge where in_valid and
    // in_ready are both high; in_ready never depends on in_valid.
    assign load_phase = (state == LEN) || (state == DATA);
    assign in_ready   = load_phase && !rst;
    assign accept     = in_valid && in_ready;

    assign ct_sel    = load_phase;
    assign ct_wren   = accept;
    assign ct_addr   = (state == LEN) ? 8'd0 : cnt;
    assign ct_wrdata = accept ? in_data : 8'd0;
    assign crack_en  = (state == START) && crack_rdy;
    assign busy      = (state != LEN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= LEN;
            len       <= 8'd0;
            cnt       <= 8'd0;
            res_valid <= 1'b0;
            res_key   <= 24'd0;
            res_found <= 1'b0;
        end else begin
            case (state)
                LEN: begin
                    if (accept) begin
                        len   <= in_data;
                        cnt   <= 8'd1;
                        state <= (in_data == 8'd0) ? START : DATA;
                    end
                end
                DATA: begin
                    // Compare before increment so a 255-byte message ends at 255.
                    if (accept) begin
                        if (cnt == len) state <= START;
                        else            cnt   <= cnt + 8'd1;
                    end
                end
                START: begin
                    if (crack_rdy) state <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (!crack_rdy) state <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (crack_rdy) begin
                        res_key   <= crack_key;
                        res_found <= crack_key_valid;
                        res_valid <= 1'b1;
                        state     <= REPORT;
                    end
                end
                REPORT: begin
                    if (res_ack) begin
                        res_valid <= 1'b0;
                        state     <= LEN;
                    end
                end
                default: state <= LEN;
            endcase
        end
    end

endmodule

// File: tb/tb_ct_loader.sv
// Self-checking bench for ct_loader: write scoreboard plus per-scenario checks
// of the crack handshake and result reporting.
module tb_ct_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        ct_sel;
    logic [7:0]  ct_addr;
    logic [7:0]  ct_wrdata;
    logic        ct_wren;
    logic        crack_en;
    logic        crack_rdy;
    logic [23:0] crack_key;
    logic        crack_key_valid;
    logic        busy;
    logic        res_valid;
    logic [23:0] res_key;
    logic        res_found;
    logic        res_ack;

    int total = 0;
    int bad   = 0;
    int en_cnt = 0;
    logic [15:0] exp_q[$];

    // model of where the next byte should land
    logic       m_expect_len = 1'b1;
    logic [7:0] m_len = 8'd0;
    logic [7:0] m_cnt = 8'd0;

    ct_loader dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .ct_sel(ct_sel), .ct_addr(ct_addr), .ct_wrdata(ct_wrdata), .ct_wren(ct_wren),
        .crack_en(crack_en), .crack_rdy(crack_rdy), .crack_key(crack_key),
        .crack_key_valid(crack_key_valid),
        .busy(busy), .res_valid(res_valid), .res_key(res_key), .res_found(res_found),
        .res_ack(res_ack)
    );

    always #5 clk = ~clk;

    // scoreboard: every write seen must match the oldest expected write
    always @(negedge clk) begin
        if (crack_en) en_cnt++;
        if (ct_wren) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_write: addr=%02h data=%02h, required no write",
                         ct_addr, ct_wrdata);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                if ({ct_addr, ct_wrdata} !== e) begin
                    bad++;
                    $display("FAIL write: addr/data=%02h/%02h, required %02h/%02h",
                             ct_addr, ct_wrdata, e[15:8], e[7:0]);
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        logic [7:0] a;
        if (m_expect_len) begin
            a = 8'd0; m_len = b; m_cnt = 8'd1; m_expect_len = (b == 8'd0);
        end else begin
            a = m_cnt;
            if (m_cnt == m_len) m_expect_len = 1'b1;
            else m_cnt = m_cnt + 8'd1;
        end
        exp_q.push_back({a, b});
        in_valid = 1'b1;
        in_data  = b;
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL in_ready_load: got %b, required 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Called one step after entering START; runs crack with `stall` cycles of
    // crack_rdy low first, then checks capture, hold and acknowledge.
    task automatic finish_crack(input logic [23:0] key, input logic kv, input int stall);
        int e0;
        e0 = en_cnt;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL pending_writes: got %0d, required 0", exp_q.size());
        end
        crack_rdy = (stall == 0);
        #1;
        for (int i = 0; i < stall; i++) begin
            total++;
            if (crack_en !== 1'b0 || busy !== 1'b1 || ct_sel !== 1'b0) begin
                bad++;
                $display("FAIL start_stall: en/busy/sel=%b%b%b, required 010",
                         crack_en, busy, ct_sel);
            end
            @(posedge clk); #1;
        end
        crack_rdy = 1'b1;
        #1;
        total++;
        if (crack_en !== 1'b1 || ct_sel !== 1'b0 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL start_pulse: en/sel/rdy=%b%b%b, required 100",
                     crack_en, ct_sel, in_ready);
        end
        @(posedge clk); #1;
        total++;
        if (crack_en !== 1'b0) begin
            bad++;
            $display("FAIL en_single: got %b, required 0", crack_en);
        end
        crack_rdy = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (res_valid !== 1'b0 || crack_en !== 1'b0) begin
            bad++;
            $display("FAIL wait_done: res_valid/en=%b%b, required 00", res_valid, crack_en);
        end
        crack_key = key; crack_key_valid = kv; crack_rdy = 1'b1;
        @(posedge clk); #1;
        crack_key = 24'($urandom); crack_key_valid = ~kv;
        total++;
        if (res_valid !== 1'b1 || res_key !== key || res_found !== kv) begin
            bad++;
            $display("FAIL capture: v/key/found=%b/%06h/%b, required 1/%06h/%b",
                     res_valid, res_key, res_found, key, kv);
        end
        total++;
        if (en_cnt != e0 + 1) begin
            bad++;
            $display("FAIL en_count: got %0d pulses, required 1", en_cnt - e0);
        end
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (res_valid !== 1'b1 || res_key !== key || res_found !== kv || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL hold: v/key/found/rdy=%b/%06h/%b/%b, required 1/%06h/%b/0",
                     res_valid, res_key, res_found, in_ready, key, kv);
        end
        res_ack = 1'b1;
        @(posedge clk); #1;
        res_ack = 1'b0;
        total++;
        if (res_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || res_key !== key) begin
            bad++;
            $display("FAIL ack: v/busy/rdy/key=%b/%b/%b/%06h, required 0/0/1/%06h",
                     res_valid, busy, in_ready, res_key, key);
        end
    endtask

    task automatic test_reset_values;
        total++;
        if (in_ready !== 1'b0 || ct_sel !== 1'b1 || ct_wren !== 1'b0 || ct_addr !== 8'd0 ||
            ct_wrdata !== 8'd0 || crack_en !== 1'b0 || busy !== 1'b0 || res_valid !== 1'b0 ||
            res_key !== 24'd0 || res_found !== 1'b0) begin
            bad++;
            $display("FAIL reset_values: rdy=%b sel=%b wren=%b addr=%02h wd=%02h en=%b busy=%b v=%b key=%06h f=%b",
                     in_ready, ct_sel, ct_wren, ct_addr, ct_wrdata, crack_en, busy,
                     res_valid, res_key, res_found);
        end
    endtask

    task automatic test_normal_load;
        send_byte(8'h03); send_byte(8'hA1); send_byte(8'hB2); send_byte(8'hC3);
        finish_crack(24'h00AB12, 1'b1, 0);
    endtask

    task automatic test_not_found_backpressure;
        send_byte(8'h02); send_byte(8'h11);
        crack_rdy = 1'b0;
        send_byte(8'h22);
        finish_crack(24'h123456, 1'b0, 5);
    endtask

    task automatic test_gaps;
        send_byte(8'h04);
        for (int i = 0; i < 4; i++) begin
            send_byte(8'($urandom_range(0, 255)));
            res_ack = (i == 1);
            if (i < 3) begin
                @(posedge clk); #1;
                total++;
                if (busy !== 1'b1 || res_valid !== 1'b0 || ct_sel !== 1'b1) begin
                    bad++;
                    $display("FAIL gap_state: busy/v/sel=%b%b%b, required 101",
                             busy, res_valid, ct_sel);
                end
            end
            res_ack = 1'b0;
        end
        finish_crack(24'hFEDCBA, 1'b1, 1);
    endtask

    task automatic test_len_zero;
        send_byte(8'h00);
        total++;
        if (busy !== 1'b1 || ct_sel !== 1'b0) begin
            bad++;
            $display("FAIL len0_start: busy/sel=%b%b, required 10", busy, ct_sel);
        end
        finish_crack(24'h000001, 1'b1, 0);
    endtask

    task automatic test_len_max;
        send_byte(8'hFF);
        for (int i = 1; i <= 255; i++) send_byte(8'($urandom_range(0, 255)));
        finish_crack(24'h3C3C3C, 1'b0, 0);
    endtask

    task automatic test_reset_mid;
        send_byte(8'h05); send_byte(8'h01); send_byte(8'h02);
        in_valid = 1'b1; in_data = 8'hFF; rst = 1'b1;
        #1;
        test_reset_values();
        @(posedge clk); #1;
        test_reset_values();
        rst = 1'b0; in_valid = 1'b0;
        m_expect_len = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL post_reset: rdy/busy=%b%b, required 10", in_ready, busy);
        end
        send_byte(8'h01); send_byte(8'h5A);
        finish_crack(24'h0F0F0F, 1'b1, 2);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; crack_rdy = 1'b1;
        crack_key = 24'd0; crack_key_valid = 1'b0; res_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        test_reset_values();
        rst = 1'b0;
        @(posedge clk); #1;
        test_normal_load();
        test_not_found_backpressure();
        test_gaps();
        test_len_zero();
        test_len_max();
        test_reset_mid();
        repeat (2) @(posedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL leftover_writes: got %0d, required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
